spi_reg_burst: RTL and testbench

- Second-generation SPI register-access slave. Serves a command byte (R/W flag plus start address) followed by an unbounded burst of REG_W-bit data words, with address auto-increment.
- SPI mode (CPOL/CPHA) and address/data widths are parametrised. Input synchronisers are built in.
- Drives a generic register-file port: a write strobe, and a read request with one-cycle return latency. It sits between the top-level SPI pins and the test-harness register bank.

---
 rtl/spi_reg_burst.sv | 199 +++++++++++++++++++
 tb/tb_spi_reg_burst.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI register-access slave, command byte plus unbounded
// word burst with address auto-increment and a 1-clk-latency read port.
module spi_reg_burst #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned REG_W  = 8,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [REG_W-1:0]  reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [REG_W-1:0]  reg_rdata,
  output logic              frame_active,
  output logic              frame_err
);

  localparam int unsigned   CW          = $clog2(REG_W);
  localparam logic [CW-1:0] CNT_CMD     = CW'(7);
  localparam logic [CW-1:0] CNT_WORD    = CW'(REG_W - 1);
  localparam bit            SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_FETCH,
    RD_DATA
  } state_t;

  logic [1:0] sck_s;
  logic [1:0] cs_s;
  logic [1:0] mosi_s;
  logic       sck_d;
  logic       cs_d;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sck_s  <= 2'b11;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sck_d  <= 1'b1;
      cs_d   <= 1'b1;
    end else if (ena) begin
      sck_s  <= {sck_s[0], spi_clk};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sck_d  <= sck_s[1];
      cs_d   <= cs_s[1];
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic sample;
  logic cs_fall;
  logic cs_rise;
  logic mosi_b;

  assign sck_rise = sck_s[1] & ~sck_d;
  assign sck_fall = ~sck_s[1] & sck_d;
  assign sample   = (SAMPLE_RISE ? sck_rise : sck_fall) & ~cs_s[1];
  assign cs_fall  = ~cs_s[1] & cs_d;
  assign cs_rise  = cs_s[1] & ~cs_d;
  assign mosi_b   = mosi_s[1];

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REG_W-1:0]    rx_q, rx_d;
  logic [REG_W-1:0]    tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REG_W-1:0]    wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                act_q, act_d;
  logic                err_q, err_d;
  logic [REG_W-1:0]    rx_next;

  assign rx_next = {rx_q[REG_W-2:0], mosi_b};

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      act_q   <= act_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    act_d   = act_q;
    err_d   = 1'b0;
    // address advances the cycle after each write strobe
    if (wr_q) addr_d = addr_q + ADDR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          act_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (sample) begin
          rx_d = rx_next;
          if (cnt_q == CNT_CMD) begin
            cnt_d   = '0;
            addr_d  = rx_next[ADDR_W-1:0];
            state_d = rx_next[7] ? WR_DATA : RD_FETCH;
            rd_d    = ~rx_next[7];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WR_DATA: begin
        if (sample) begin
          rx_d = rx_next;
          if (cnt_q == CNT_WORD) begin
            cnt_d   = '0;
            wr_d    = 1'b1;
            wdata_d = rx_next;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RD_FETCH: begin
        // first cycle carries the request, second captures the data
        if (!rd_q) begin
          tx_d    = reg_rdata;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (sample) begin
          tx_d = tx_q << 1;
          if (cnt_q == CNT_WORD) begin
            cnt_d   = '0;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD_FETCH;
            rd_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && cs_rise) begin
      err_d   = (cnt_d != '0);
      state_d = IDLE;
      act_d   = 1'b0;
      cnt_d   = '0;
      rd_d    = 1'b0;
    end
  end

  assign spi_miso     = (state_q == RD_DATA) ? tx_q[REG_W-1] : 1'b0;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_wr_en    = wr_q & ena;
  assign reg_rd_en    = rd_q & ena;
  assign frame_active = act_q;
  assign frame_err    = err_q & ena;

endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: five slaves (modes 0-3 at 8 bits, mode 1 at 16 bits)
// driven by one bit-banged master and checked against a frame-level model.
module tb_spi_reg_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb, ena, cs_n, mosi, ph;
  logic [4:0] sck, miso, wre, rde, act, ferr;
  logic [6:0] addr [5];
  logic [7:0] wd8 [4];
  logic [7:0] rd8 [4];
  logic [15:0] wd16, rd16;

  assign sck = {ph, ~ph, ~ph, ph, ph};
  localparam logic [4:0] CPHA_V = 5'b11010;

  for (genvar m = 0; m < 4; m++) begin : g_m
    spi_reg_burst #(
      .ADDR_W(7), .REG_W(8), .CPOL(m >= 2), .CPHA(m % 2 == 1)
    ) u_dut (
      .clk(clk), .rstb(rstb), .ena(ena),
      .spi_clk(sck[m]), .spi_cs_n(cs_n), .spi_mosi(mosi),
      .spi_miso(miso[m]), .reg_addr(addr[m]),
      .reg_wdata(wd8[m]), .reg_wr_en(wre[m]), .reg_rd_en(rde[m]),
      .reg_rdata(rd8[m]), .frame_active(act[m]), .frame_err(ferr[m])
    );
  end

  spi_reg_burst #(
    .ADDR_W(7), .REG_W(16), .CPOL(1'b0), .CPHA(1'b1)
  ) u_w16 (
    .clk(clk), .rstb(rstb), .ena(ena),
    .spi_clk(sck[4]), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso[4]), .reg_addr(addr[4]),
    .reg_wdata(wd16), .reg_wr_en(wre[4]), .reg_rd_en(rde[4]),
    .reg_rdata(rd16), .frame_active(act[4]), .frame_err(ferr[4])
  );

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_wr [5][$];
  int  exp_rd [5][$];
  bit  exp_mi [5][$];
  bit  frame_bits [$];
  int  exp_err [5];
  int  err_cnt [5];
  int  tot_err [5];
  int  m_addr [5];
  int  lw_a [5];
  int  lw_d [5];
  int  mi_cap [5];
  bit  pre_v [5];
  int  checks = 0;
  int  errors = 0;

  function automatic int wid(int i);
    return (i == 4) ? 16 : 8;
  endfunction

  // register bank contents seen by reads
  function automatic int bank(int a, int w);
    if (w == 8) return (a + 16) & 255;
    return (((a << 8) | a) + 16) & 65535;
  endfunction

  function automatic int get_wd(int i);
    return (i == 4) ? int'(wd16) : int'(wd8[i]);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected strobe", name);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rde[i]) rd8[i] <= 8'(bank(int'(addr[i]), 8));
    if (rde[4]) rd16 <= 16'(bank(int'(addr[4]), 16));
  end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      wr_t e;
      if (wre[i]) begin
        if (exp_wr[i].size() == 0) begin
          fail($sformatf("wr_extra[%0d]", i));
        end else begin
          e = exp_wr[i].pop_front();
          chk($sformatf("wr_addr[%0d]", i), 32'(addr[i]), 32'(e.a));
          chk($sformatf("wr_data[%0d]", i), get_wd(i), e.d);
        end
        lw_a[i] = int'(addr[i]);
        lw_d[i] = get_wd(i);
      end
      if (rde[i]) begin
        if (exp_rd[i].size() == 0)
          fail($sformatf("rd_extra[%0d]", i));
        else
          chk($sformatf("rd_addr[%0d]", i), 32'(addr[i]),
              exp_rd[i].pop_front());
      end
      if (ferr[i]) begin
        err_cnt[i]++;
        tot_err[i]++;
      end
    end
  end

  task automatic add(input logic [31:0] v, input int n);
    for (int b = n - 1; b >= 0; b--) frame_bits.push_back(v[b]);
  endtask

  task automatic model(input int n, input bit ab);
    for (int i = 0; i < 5; i++) begin
      int w, cmd, a, nw, rem, d, k, b;
      wr_t e;
      w = wid(i);
      cmd = 0;
      exp_err[i] = 0;
      for (int j = 0; j < n; j++) exp_mi[i].push_back(1'b0);
      if (n < 8) begin
        exp_err[i] = (n > 0 && !ab) ? 1 : 0;
      end else begin
        for (int j = 0; j < 8; j++) cmd = (cmd << 1) | int'(frame_bits[j]);
        a = cmd & 127;
        nw = (n - 8) / w;
        rem = (n - 8) % w;
        exp_err[i] = (rem != 0 && !ab) ? 1 : 0;
        if (((cmd >> 7) & 1) == 1) begin
          for (int q = 0; q < nw; q++) begin
            d = 0;
            for (int p = 0; p < w; p++)
              d = (d << 1) | int'(frame_bits[8 + q * w + p]);
            e.a = 7'((a + q) & 127);
            e.d = d;
            exp_wr[i].push_back(e);
          end
        end else begin
          for (int q = 0; q <= nw; q++) exp_rd[i].push_back((a + q) & 127);
          for (int j = 8; j < n; j++) begin
            k = (j - 8) / w;
            b = (j - 8) % w;
            exp_mi[i][j] = bit'((bank((a + k) & 127, w) >> (w - 1 - b)) & 1);
          end
        end
        m_addr[i] = (a + nw) & 127;
      end
      if (ab) m_addr[i] = 0;
    end
  endtask

  task automatic reset_vals(string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), 32'(addr[i]), 0);
      chk($sformatf("%s_wdata[%0d]", tag, i), get_wd(i), 0);
      chk($sformatf("%s_wr[%0d]", tag, i), 32'(wre[i]), 0);
      chk($sformatf("%s_rd[%0d]", tag, i), 32'(rde[i]), 0);
      chk($sformatf("%s_act[%0d]", tag, i), 32'(act[i]), 0);
      chk($sformatf("%s_miso[%0d]", tag, i), 32'(miso[i]), 0);
      chk($sformatf("%s_err[%0d]", tag, i), 32'(ferr[i]), 0);
    end
  endtask

  task automatic pre(input bit p, input bit en);
    for (int i = 0; i < 5; i++) begin
      bit e;
      if (CPHA_V[i] == p) begin
        e = 1'b0;
        if (en && exp_mi[i].size() > 0) e = exp_mi[i].pop_front();
        chk($sformatf("miso[%0d]", i), 32'(miso[i]), 32'(e));
        chk($sformatf("active[%0d]", i), 32'(act[i]), 32'(en));
        pre_v[i] = miso[i];
        mi_cap[i] = (mi_cap[i] << 1) | int'(miso[i]);
      end
    end
  endtask

  task automatic post(input bit p);
    for (int i = 0; i < 5; i++)
      if (CPHA_V[i] == p)
        chk($sformatf("miso_stable[%0d]", i), 32'(miso[i]), 32'(pre_v[i]));
  endtask

  task automatic drive_bit(input bit b, input bit en);
    mosi = b;
    repeat (2) @(negedge clk);
    pre(1'b0, en);
    ph = 1'b1;
    @(negedge clk);
    post(1'b0);
    repeat (3) @(negedge clk);
    pre(1'b1, en);
    ph = 1'b0;
    @(negedge clk);
    post(1'b1);
    @(negedge clk);
  endtask

  task automatic run_frame(input bit en, input int rst_at);
    int n;
    n = (rst_at >= 0) ? rst_at : frame_bits.size();
    for (int i = 0; i < 5; i++) begin
      mi_cap[i] = 0;
      exp_err[i] = 0;
    end
    if (en) model(n, rst_at >= 0);
    if (!en) ena = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < n; j++) drive_bit(frame_bits[j], en);
    repeat (8) @(negedge clk);
    if (rst_at >= 0) begin
      rstb = 1'b0;
      cs_n = 1'b1;
      @(negedge clk);
      reset_vals("midrst");
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
    if (!en) ena = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wr_left[%0d]", i), exp_wr[i].size(), 0);
      chk($sformatf("rd_left[%0d]", i), exp_rd[i].size(), 0);
      chk($sformatf("frame_err[%0d]", i), err_cnt[i], exp_err[i]);
      chk($sformatf("end_addr[%0d]", i), 32'(addr[i]), m_addr[i]);
      chk($sformatf("end_act[%0d]", i), 32'(act[i]), 0);
      exp_wr[i].delete();
      exp_rd[i].delete();
      exp_mi[i].delete();
      err_cnt[i] = 0;
    end
    frame_bits.delete();
  endtask

  initial begin
    rstb = 1'b0;
    ena  = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    ph   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_addr[i] = 0;
      err_cnt[i] = 0;
      tot_err[i] = 0;
      lw_a[i] = -1;
      lw_d[i] = -1;
    end
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    add(32'h85, 8); add(32'h3C, 8);
    run_frame(1'b1, -1);
    chk("lit_w1_addr", lw_a[0], 5);
    chk("lit_w1_data", lw_d[0], 32'h3C);

    add(32'h7E, 8); add(32'h0, 24);
    run_frame(1'b1, -1);
    chk("lit_rd_m3", mi_cap[3], 32'h008E8F10);
    chk("lit_rd_w16", mi_cap[4], 32'h007E8E7F);

    add(32'h82, 8); add(32'hBEEF, 16); add(32'h1234, 16);
    run_frame(1'b1, -1);
    chk("lit_bw_addr", lw_a[4], 3);
    chk("lit_bw_data", lw_d[4], 32'h1234);
    chk("lit_bw_end", 32'(addr[4]), 4);

    add(32'h81, 8); add(32'h5, 3);
    run_frame(1'b1, -1);
    chk("lit_err_m0", tot_err[0], 1);
    chk("lit_err_w16", tot_err[4], 3);

    add(32'h85, 8); add(32'h3CA55AC3, 32);
    run_frame(1'b1, -1);

    add(32'h90, 8); add(32'h11, 8);
    run_frame(1'b0, -1);

    add(32'h05, 8); add(32'h0, 16);
    run_frame(1'b1, -1);
    chk("lit_rd2_m0", mi_cap[0], 32'h00001516);

    add(32'h84, 8); add(32'h1122, 16); add(32'h16, 5);
    run_frame(1'b1, 29);

    add(32'hFF, 8); add(32'h7766, 16);
    run_frame(1'b1, -1);
    chk("lit_wrap_m0", lw_a[0], 0);
    chk("lit_wrap_end", 32'(addr[4]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
